mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of all address buses.
REQ-002 Parameter DATA_WIDTH, default 32, width of all data buses.
REQ-003 Parameter STARVE_LIMIT, default 3, consecutive denied fetch cycles before fetch is forced to win.
REQ-004 Ports SHALL be as follows; clk and reset first, one clock, reset synchronous and active-high:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  instruction-fetch read request
if_addr  in  ADDR_WIDTH  fetch byte address
if_gnt  out  1  fetch granted this cycle
if_rdata  out  DATA_WIDTH  registered fetch read data
if_rvalid  out  1  if_rdata valid, one-cycle pulse
d_req  in  1  data-port request
d_we  in  1  data-port write enable (1 write, 0 read)
d_addr  in  ADDR_WIDTH  data byte address
d_wdata  in  DATA_WIDTH  store data
d_gnt  out  1  data port granted this cycle
d_rdata  out  DATA_WIDTH  registered load data
d_rvalid  out  1  d_rdata valid, one-cycle pulse
mem_addr  out  ADDR_WIDTH  to unified memory ADDR
mem_we  out  1  to unified memory WE
mem_wd  out  DATA_WIDTH  to unified memory WD
mem_rd  in  DATA_WIDTH  from unified memory RD (combinational read)

Function
REQ-005 Exactly one requester SHALL be granted per cycle; if_gnt and d_gnt SHALL never both be 1.
REQ-006 Grant SHALL be combinational from the current-cycle inputs and starvation state.
REQ-007 Only if_req: if_gnt=1. Only d_req: d_gnt=1. Neither: both 0.
REQ-008 Both requesting: d_gnt=1 unless starve_cnt == STARVE_LIMIT, in which case if_gnt=1.
REQ-009 starve_cnt (width ceil(log2(STARVE_LIMIT+1))) SHALL increment when if_req=1 and if_gnt=0, saturating at STARVE_LIMIT.
REQ-010 starve_cnt SHALL clear to 0 on any cycle where if_gnt=1 or if_req=0.
REQ-011 mem_addr SHALL equal the granted requester's address; with no grant it SHALL hold if_addr.
REQ-012 mem_we SHALL be 1 only when d_gnt=1 and d_we=1; otherwise 0.
REQ-013 mem_wd SHALL equal d_wdata at all times.
REQ-014 On a fetch grant, mem_rd SHALL be captured into if_rdata at the same clock edge, and if_rvalid SHALL be 1 for exactly the following cycle (latency 1).
REQ-015 On a data read grant (d_we=0), mem_rd SHALL be captured into d_rdata, and d_rvalid SHALL be 1 for exactly the following cycle.
REQ-016 A data write grant SHALL produce no d_rvalid; the write completes at the granting edge.
REQ-017 if_rdata and d_rdata SHALL hold their last captured value until the next capture on that port.
REQ-018 A requester not granted SHALL hold req, address and data stable; the arbiter does not queue requests.
REQ-019 Back-to-back grants to the same port on consecutive cycles SHALL be supported; rvalid then stays 1 across cycles.
REQ-020 A requester dropping req in the same cycle it would be granted SHALL simply not be granted; no response is generated.

Reset
REQ-021 While reset=1 at a rising edge: starve_cnt=0, if_rdata=0, d_rdata=0, if_rvalid=0, d_rvalid=0.
REQ-022 While reset=1, if_gnt, d_gnt and mem_we SHALL be forced to 0 regardless of requests.
REQ-023 Reset asserted the cycle after a grant SHALL suppress the pending rvalid pulse.

Verification
REQ-024 Only if_req=1, if_addr=0x10, memory word 0xE3A01005 -> if_gnt=1 same cycle; next cycle if_rvalid=1, if_rdata=0xE3A01005.
REQ-025 Only d_req=1, d_we=1, d_addr=0x80, d_wdata=0xDEADBEEF -> mem_we=1 one cycle, d_rvalid stays 0; a later d_req read of 0x80 returns d_rdata=0xDEADBEEF.
REQ-026 if_req and d_req held high together for 8 cycles, STARVE_LIMIT=3 -> grant pattern D,D,D,I,D,D,D,I; never both grants.
REQ-027 if_req held, d_req pulses once at cycle 2 -> if_gnt=1 on all cycles except cycle 2; starve_cnt returns to 0 at cycle 3.
REQ-028 reset=1 in the cycle after a fetch grant -> if_rvalid=0, if_rdata=0, if_gnt=0 while reset held.
REQ-029 Random if_req/d_req/d_we for 10k cycles against a reference model -> rdata matches model, mutual-exclusion and starvation bound (fetch waits at most STARVE_LIMIT cycles) never violated.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one combinational-read memory between instruction fetch and data.
// Data normally wins a collision. Fetch is forced through after STARVE_LIMIT consecutive denials.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_rvalid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  localparam int            SW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic                  if_gnt_w, d_gnt_w;

  always_comb begin
    if_gnt_w = 1'b0;
    d_gnt_w  = 1'b0;
    if (!reset) begin
      if (if_req && (!d_req || (starve_cnt_q == LIMIT))) begin
        if_gnt_w = 1'b1;
      end else if (d_req) begin
        d_gnt_w = 1'b1;
      end
    end
  end

  always_comb begin
    starve_cnt_d = '0;
    if (if_req && !if_gnt_w) begin
      starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 1'b1;
    end
    if_rdata_d  = if_gnt_w ? mem_rd : if_rdata_q;
    if_rvalid_d = if_gnt_w;
    d_rdata_d   = (d_gnt_w && !d_we) ? mem_rd : d_rdata_q;
    d_rvalid_d  = d_gnt_w && !d_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      if_rdata_q   <= '0;
      if_rvalid_q  <= 1'b0;
      d_rdata_q    <= '0;
      d_rvalid_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      if_rdata_q   <= if_rdata_d;
      if_rvalid_q  <= if_rvalid_d;
      d_rdata_q    <= d_rdata_d;
      d_rvalid_q   <= d_rvalid_d;
    end
  end

  assign if_gnt   = if_gnt_w;
  assign d_gnt    = d_gnt_w;
  assign mem_addr = d_gnt_w ? d_addr : if_addr;
  assign mem_we   = d_gnt_w & d_we;
  assign mem_wd   = d_wdata;

  // Reset masks the response outputs immediately so a pulse pending from the prior grant never shows.
  assign if_rvalid = if_rvalid_q & ~reset;
  assign if_rdata  = reset ? '0 : if_rdata_q;
  assign d_rvalid  = d_rvalid_q & ~reset;
  assign d_rdata   = reset ? '0 : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_mem_arbiter;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset, if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rd;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wd;

  logic [31:0] tb_mem  [0:255];
  logic [31:0] ref_mem [0:255];
  int checks = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  assign mem_rd = tb_mem[mem_addr[9:2]];

  // Memory write sampled before the edge, applied at the following negedge (ports are exclusive).
  task automatic advance();
    logic w;
    logic [7:0] a;
    logic [31:0] v;
    w = mem_we; a = mem_addr[9:2]; v = mem_wd;
    @(negedge clk);
    if (w) tb_mem[a] = v;
  endtask

  task automatic test_reset();
    if_req = 1; d_req = 1; d_we = 1; if_addr = 32'h10; d_addr = 32'h80; d_wdata = 32'h55;
    #1;
    checks++; if (if_gnt !== 1'b0) begin failures++; $display("FAIL reset_if_gnt got=%b exp=0", if_gnt); end
    checks++; if (d_gnt !== 1'b0) begin failures++; $display("FAIL reset_d_gnt got=%b exp=0", d_gnt); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    advance(); #1;
    checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b%b exp=00", if_rvalid, d_rvalid); end
    checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata, d_rdata); end
    if_req = 0; d_req = 0; d_we = 0;
    reset = 0;
    advance();
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 32'h10; d_req = 0;
    #1;
    checks++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin failures++; $display("FAIL fetch_gnt got=%b%b exp=10", if_gnt, d_gnt); end
    checks++; if (mem_addr !== 32'h10) begin failures++; $display("FAIL fetch_mem_addr got=%h exp=10", mem_addr); end
    advance(); if_req = 0; #1;
    checks++; if (if_rvalid !== 1'b1) begin failures++; $display("FAIL fetch_rvalid got=%b exp=1", if_rvalid); end
    checks++; if (if_rdata !== 32'hE3A01005) begin failures++; $display("FAIL fetch_rdata got=%h exp=e3a01005", if_rdata); end
    advance(); #1;
    checks++; if (if_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_rvalid_pulse got=%b exp=0", if_rvalid); end
    checks++; if (if_rdata !== 32'hE3A01005) begin failures++; $display("FAIL fetch_rdata_hold got=%h exp=e3a01005", if_rdata); end
  endtask

  task automatic test_write_read();
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hDEADBEEF; if_req = 0; if_addr = 32'h10;
    #1;
    checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL wr_gnt_we got=%b%b exp=11", d_gnt, mem_we); end
    checks++; if (mem_addr !== 32'h80 || mem_wd !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_bus got=%h/%h exp=80/deadbeef", mem_addr, mem_wd); end
    advance(); d_req = 0; #1;
    checks++; if (mem_we !== 1'b0 || d_rvalid !== 1'b0) begin failures++; $display("FAIL wr_after got we=%b rvalid=%b exp=0/0", mem_we, d_rvalid); end
    advance(); d_req = 1; d_we = 0; #1;
    checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL rd_gnt_we got=%b%b exp=10", d_gnt, mem_we); end
    advance(); d_req = 0; #1;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%b/%h exp=1/deadbeef", d_rvalid, d_rdata); end
    advance();
  endtask

  task automatic test_starve();
    logic prev_i, prev_d, ei;
    prev_i = 0; prev_d = 0;
    if_req = 1; d_req = 1; d_we = 0; if_addr = 32'h10; d_addr = 32'h20;
    for (int c = 0; c < 8; c++) begin
      #1;
      ei = ((c % 4) == 3);
      checks++; if (if_gnt !== ei || d_gnt !== !ei) begin failures++; $display("FAIL starve_pattern c=%0d got=%b%b exp=%b%b", c, if_gnt, d_gnt, ei, !ei); end
      checks++; if (if_gnt && d_gnt) begin failures++; $display("FAIL starve_mutex c=%0d got=11 exp=not both", c); end
      checks++; if (if_rvalid !== prev_i || d_rvalid !== prev_d) begin failures++; $display("FAIL starve_rvalid c=%0d got=%b%b exp=%b%b", c, if_rvalid, d_rvalid, prev_i, prev_d); end
      if (prev_d) begin
        checks++; if (d_rdata !== 32'h12345678) begin failures++; $display("FAIL starve_d_rdata c=%0d got=%h exp=12345678", c, d_rdata); end
      end
      prev_i = ei; prev_d = !ei;
      advance();
    end
    if_req = 0; d_req = 0;
    advance();
  endtask

  task automatic test_pulse();
    logic ei;
    if_req = 1; if_addr = 32'h10; d_addr = 32'h20; d_we = 0;
    for (int c = 0; c < 6; c++) begin
      d_req = (c == 2);
      #1;
      checks++; if (if_gnt !== (c != 2) || d_gnt !== (c == 2)) begin failures++; $display("FAIL pulse_gnt c=%0d got=%b%b exp=%b%b", c, if_gnt, d_gnt, c != 2, c == 2); end
      if (c == 3) begin
        checks++; if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin failures++; $display("FAIL pulse_rvalid got=%b%b exp=01", if_rvalid, d_rvalid); end
      end
      advance();
    end
    // Counter must have cleared: a fresh collision run yields D,D,D,I again.
    d_req = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      ei = (c == 3);
      checks++; if (if_gnt !== ei || d_gnt !== !ei) begin failures++; $display("FAIL pulse_recount c=%0d got=%b%b exp=%b%b", c, if_gnt, d_gnt, ei, !ei); end
      advance();
    end
    if_req = 0; d_req = 0;
    advance();
  endtask

  task automatic test_reset_after_grant();
    if_req = 1; if_addr = 32'h10; d_req = 0;
    #1;
    checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL rag_gnt got=%b exp=1", if_gnt); end
    advance(); reset = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0 || if_gnt !== 1'b0) begin failures++; $display("FAIL rag_held c=%0d got rvalid=%b rdata=%h gnt=%b exp=0/0/0", c, if_rvalid, if_rdata, if_gnt); end
      advance();
    end
    reset = 0; if_req = 0;
    advance();
  endtask

  task automatic test_random();
    logic e_ifv, e_dv, eig, edg;
    logic [31:0] e_ifd, e_dd, v;
    int denied, wait_cnt;
    reset = 1; if_req = 0; d_req = 0; d_we = 0;
    for (int i = 0; i < 256; i++) begin v = $urandom; tb_mem[i] = v; ref_mem[i] = v; end
    advance(); advance();
    e_ifv = 0; e_dv = 0; e_ifd = 0; e_dd = 0; denied = 0; wait_cnt = 0;
    for (int c = 0; c < 10000; c++) begin
      reset   = ($urandom_range(0, 99) == 0);
      if_req  = ($urandom_range(0, 3) != 0);
      d_req   = ($urandom_range(0, 1) == 1);
      d_we    = ($urandom_range(0, 1) == 1);
      if_addr = {22'b0, 8'($urandom), 2'b00};
      d_addr  = {22'b0, 8'($urandom), 2'b00};
      d_wdata = $urandom;
      #1;
      eig = !reset && if_req && (!d_req || denied == LIMIT);
      edg = !reset && d_req && !eig;
      checks++; if (if_gnt && d_gnt) begin failures++; $display("FAIL rnd_mutex c=%0d got=11 exp=not both", c); end
      checks++; if (if_gnt !== eig || d_gnt !== edg) begin failures++; $display("FAIL rnd_gnt c=%0d got=%b%b exp=%b%b", c, if_gnt, d_gnt, eig, edg); end
      checks++; if (mem_we !== (edg && d_we)) begin failures++; $display("FAIL rnd_mem_we c=%0d got=%b exp=%b", c, mem_we, edg && d_we); end
      checks++; if (mem_addr !== (edg ? d_addr : if_addr)) begin failures++; $display("FAIL rnd_mem_addr c=%0d got=%h exp=%h", c, mem_addr, edg ? d_addr : if_addr); end
      checks++; if (mem_wd !== d_wdata) begin failures++; $display("FAIL rnd_mem_wd c=%0d got=%h exp=%h", c, mem_wd, d_wdata); end
      checks++; if (if_rvalid !== (e_ifv && !reset)) begin failures++; $display("FAIL rnd_if_rvalid c=%0d got=%b exp=%b", c, if_rvalid, e_ifv && !reset); end
      checks++; if (if_rdata !== (reset ? 32'h0 : e_ifd)) begin failures++; $display("FAIL rnd_if_rdata c=%0d got=%h exp=%h", c, if_rdata, reset ? 32'h0 : e_ifd); end
      checks++; if (d_rvalid !== (e_dv && !reset)) begin failures++; $display("FAIL rnd_d_rvalid c=%0d got=%b exp=%b", c, d_rvalid, e_dv && !reset); end
      checks++; if (d_rdata !== (reset ? 32'h0 : e_dd)) begin failures++; $display("FAIL rnd_d_rdata c=%0d got=%h exp=%h", c, d_rdata, reset ? 32'h0 : e_dd); end
      if (!reset && if_req && !if_gnt) wait_cnt++; else wait_cnt = 0;
      checks++; if (wait_cnt > LIMIT) begin failures++; $display("FAIL rnd_starve_bound c=%0d got=%0d exp<=%0d", c, wait_cnt, LIMIT); end
      if (reset) begin
        e_ifv = 0; e_dv = 0; e_ifd = 0; e_dd = 0; denied = 0;
      end else begin
        e_ifv = eig;
        if (eig) e_ifd = ref_mem[if_addr[9:2]];
        e_dv = edg && !d_we;
        if (e_dv) e_dd = ref_mem[d_addr[9:2]];
        if (edg && d_we) ref_mem[d_addr[9:2]] = d_wdata;
        denied = (if_req && !eig) ? ((denied < LIMIT) ? denied + 1 : LIMIT) : 0;
      end
      advance();
    end
    reset = 0; if_req = 0; d_req = 0;
  endtask

  initial begin
    reset = 1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
    tb_mem[4] = 32'hE3A01005;
    tb_mem[8] = 32'h12345678;
    @(negedge clk); @(negedge clk);
    test_reset();
    test_fetch();
    test_write_read();
    test_starve();
    test_pulse();
    test_reset_after_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
